d_e_stage: RTL and testbench
============================

Name: d_e_stage

Overview:
- Decode/Execute boundary stage that sits directly upstream of E_ALU.
- Registers the decoded instruction fields from the D stage and resolves M- and W-stage forwarding.
- Performs immediate extension and drives E_ALU's ALUcontrol, Op1 and Op2, plus the E-stage control and store data that travel on to the M stage.
- Generates the load-use stall request back to the D stage.

Parameters:
- WIDTH, 32, datapath width of register data, PC and operands
- RADDR, 5, register-address width

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- D_valid  in  1  D holds a real instruction
- D_PC  in  WIDTH  PC of the D instruction
- D_rs_data  in  WIDTH  GRF read data for rs
- D_rt_data  in  WIDTH  GRF read data for rt
- D_rs_addr  in  RADDR  rs index
- D_rt_addr  in  RADDR  rt index
- D_rd_addr  in  RADDR  destination index, already selected by decode
- D_imm16  in  16  instruction immediate
- D_ALUcontrol  in  3  ALU operation code
- D_ALUSrc  in  1  1 selects the extended immediate as Op2
- D_ExtOp  in  1  1 sign-extend, 0 zero-extend
- D_uses_rt  in  1  instruction reads rt (R-type, store, beq)
- D_RegWrite  in  1  writes the GRF
- D_MemWrite  in  1  store
- D_MemtoReg  in  1  load
- E_hold  in  1  freeze the E register (downstream stall)
- E_flush  in  1  load a bubble into E
- M_RegWrite  in  1  M-stage instruction writes the GRF
- M_rd_addr  in  RADDR  M-stage destination
- M_fwd_data  in  WIDTH  M-stage result (ALUResult)
- W_RegWrite  in  1  W-stage instruction writes the GRF
- W_rd_addr  in  RADDR  W-stage destination
- W_fwd_data  in  WIDTH  W-stage writeback data
- ALUcontrol  out  3  to E_ALU
- Op1  out  WIDTH  to E_ALU
- Op2  out  WIDTH  to E_ALU
- E_wdata  out  WIDTH  forwarded rt, used as store data
- E_rd_addr  out  RADDR  registered destination
- E_RegWrite  out  1  registered control
- E_MemWrite  out  1  registered control
- E_MemtoReg  out  1  registered control
- E_PC  out  WIDTH  registered PC
- E_valid  out  1  E holds a real instruction
- stall_req  out  1  load-use hazard; D/F must hold and E_flush must be driven

Behaviour:
- Reset: rst_n low clears every E register to 0 asynchronously.
  - Result: ALUcontrol=0, E_valid=0, all E controls=0, E_PC=0, E_rd_addr=0.
  - Op1 and Op2 then evaluate to 0 unless forwarding sources are non-zero for index 0, which is never allowed (see forwarding rules).
- Rising clk with rst_n high, in priority order:
  - E_hold=1: all E registers keep their values.
  - E_flush=1: bubble. All E registers are cleared, identical to the reset value.
  - Otherwise: capture all D_* fields.
  - If D_valid=0, a bubble is captured regardless of the D fields.
- E_hold beats E_flush. A flush that arrives during a hold is dropped, and the hazard/branch controller must re-assert it.
- Latency: one clock from D fields to E registers. Op1, Op2 and E_wdata are combinational from the E registers and the current M/W inputs.
- Forwarding, per source index s in {E_rs, E_rt}:
  - If s!=0 and M_RegWrite and M_rd_addr==s, use M_fwd_data.
  - Else if s!=0 and W_RegWrite and W_rd_addr==s, use W_fwd_data.
  - Else use the registered GRF data.
  - M has priority over W. Index 0 always yields the registered data (0 from the GRF).
- Op1 = forwarded rs.
- E_wdata = forwarded rt.
- Op2 = D_ALUSrc(registered) ? ext(imm16) : forwarded rt.
  - ext: sign-extend when ExtOp=1, otherwise zero-extend to WIDTH.
- Forwarding never uses an M-stage load result: M_fwd_data carries the ALU result, so loads are covered by stall_req.
- stall_req = E_valid & E_MemtoReg & (E_rd_addr!=0) & ((E_rd_addr==D_rs_addr) | (D_uses_rt & E_rd_addr==D_rt_addr)).
  - Purely combinational. Held by an asserted E_hold.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with the E register loaded -> all outputs 0 immediately, without waiting for clk.
- Plain capture: D_rs_data=32'hf0000000, D_rt_data=32'hf0000002, ALUcontrol=3'b110, ALUSrc=0 -> one clk later Op1=f0000000, Op2=f0000002, ALUcontrol=110, E_valid=1.
- Immediate extension: imm16=16'h8001, ALUSrc=1 -> ExtOp=1 gives Op2=ffff8001; ExtOp=0 gives Op2=00008001.
- Forward priority: E_rs=5, M_RegWrite=1/M_rd=5/M_fwd=0000aaaa, W_RegWrite=1/W_rd=5/W_fwd=0000bbbb -> Op1=0000aaaa. Drop M_RegWrite -> Op1=0000bbbb. With rs=0 and both matching 0 -> Op1=GRF value 0.
- Load-use: E holds a load to r8, D reads rt=8 with D_uses_rt=1 -> stall_req=1. With D_uses_rt=0 and rs!=8 -> stall_req=0. With E_rd=0 -> stall_req=0.
- Hold vs flush: E_hold=1 and E_flush=1 together for one clk -> contents unchanged. E_flush alone -> E_valid=0, E_RegWrite=0, E_MemWrite=0.

Source files
------------

// File: rtl/d_e_stage.sv
// D/E pipeline register with M/W forwarding, immediate extension and load-use stall detection.
// Latency: one clk from D to E; Op1/Op2/E_wdata are combinational. E_hold freezes E, and E_flush or D_valid=0 inserts a bubble.
module d_e_stage #(
  parameter int WIDTH = 32,
  parameter int RADDR = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             D_valid,
  input  logic [WIDTH-1:0] D_PC,
  input  logic [WIDTH-1:0] D_rs_data,
  input  logic [WIDTH-1:0] D_rt_data,
  input  logic [RADDR-1:0] D_rs_addr,
  input  logic [RADDR-1:0] D_rt_addr,
  input  logic [RADDR-1:0] D_rd_addr,
  input  logic [15:0]      D_imm16,
  input  logic [2:0]       D_ALUcontrol,
  input  logic             D_ALUSrc,
  input  logic             D_ExtOp,
  input  logic             D_uses_rt,
  input  logic             D_RegWrite,
  input  logic             D_MemWrite,
  input  logic             D_MemtoReg,
  input  logic             E_hold,
  input  logic             E_flush,
  input  logic             M_RegWrite,
  input  logic [RADDR-1:0] M_rd_addr,
  input  logic [WIDTH-1:0] M_fwd_data,
  input  logic             W_RegWrite,
  input  logic [RADDR-1:0] W_rd_addr,
  input  logic [WIDTH-1:0] W_fwd_data,
  output logic [2:0]       ALUcontrol,
  output logic [WIDTH-1:0] Op1,
  output logic [WIDTH-1:0] Op2,
  output logic [WIDTH-1:0] E_wdata,
  output logic [RADDR-1:0] E_rd_addr,
  output logic             E_RegWrite,
  output logic             E_MemWrite,
  output logic             E_MemtoReg,
  output logic [WIDTH-1:0] E_PC,
  output logic             E_valid,
  output logic             stall_req
);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic [RADDR-1:0] rs_addr;
    logic [RADDR-1:0] rt_addr;
    logic [RADDR-1:0] rd_addr;
    logic [15:0]      imm16;
    logic [2:0]       alu_ctl;
    logic             alu_src;
    logic             ext_op;
    logic             reg_write;
    logic             mem_write;
    logic             mem_to_reg;
  } e_regs_t;

  e_regs_t e_q, e_d, d_fields;

  logic [WIDTH-1:0] rs_fwd, rt_fwd, imm_ext;

  always_comb begin
    d_fields            = '0;
    d_fields.valid      = D_valid;
    d_fields.pc         = D_PC;
    d_fields.rs_data    = D_rs_data;
    d_fields.rt_data    = D_rt_data;
    d_fields.rs_addr    = D_rs_addr;
    d_fields.rt_addr    = D_rt_addr;
    d_fields.rd_addr    = D_rd_addr;
    d_fields.imm16      = D_imm16;
    d_fields.alu_ctl    = D_ALUcontrol;
    d_fields.alu_src    = D_ALUSrc;
    d_fields.ext_op     = D_ExtOp;
    d_fields.reg_write  = D_RegWrite;
    d_fields.mem_write  = D_MemWrite;
    d_fields.mem_to_reg = D_MemtoReg;
  end

  // Hold wins over flush; a flush seen during a hold is simply lost.
  always_comb begin
    e_d = e_q;
    if (!E_hold) begin
      if (E_flush || !D_valid) e_d = '0;
      else                     e_d = d_fields;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) e_q <= '0;
    else        e_q <= e_d;
  end

  // Index 0 never forwards, so r0 always reads the registered GRF value.
  always_comb begin
    rs_fwd = e_q.rs_data;
    if (e_q.rs_addr != '0 && M_RegWrite && M_rd_addr == e_q.rs_addr)
      rs_fwd = M_fwd_data;
    else if (e_q.rs_addr != '0 && W_RegWrite && W_rd_addr == e_q.rs_addr)
      rs_fwd = W_fwd_data;
  end

  always_comb begin
    rt_fwd = e_q.rt_data;
    if (e_q.rt_addr != '0 && M_RegWrite && M_rd_addr == e_q.rt_addr)
      rt_fwd = M_fwd_data;
    else if (e_q.rt_addr != '0 && W_RegWrite && W_rd_addr == e_q.rt_addr)
      rt_fwd = W_fwd_data;
  end

  always_comb begin
    if (e_q.ext_op) imm_ext = {{(WIDTH-16){e_q.imm16[15]}}, e_q.imm16};
    else            imm_ext = {{(WIDTH-16){1'b0}}, e_q.imm16};
  end

  assign Op1        = rs_fwd;
  assign Op2        = e_q.alu_src ? imm_ext : rt_fwd;
  assign E_wdata    = rt_fwd;
  assign ALUcontrol = e_q.alu_ctl;
  assign E_rd_addr  = e_q.rd_addr;
  assign E_RegWrite = e_q.reg_write;
  assign E_MemWrite = e_q.mem_write;
  assign E_MemtoReg = e_q.mem_to_reg;
  assign E_PC       = e_q.pc;
  assign E_valid    = e_q.valid;

  // M_fwd_data is an ALU result, so a load in E must stall its consumer in D.
  assign stall_req = e_q.valid && e_q.mem_to_reg && (e_q.rd_addr != '0) &&
                     ((e_q.rd_addr == D_rs_addr) ||
                      (D_uses_rt && (e_q.rd_addr == D_rt_addr)));

endmodule

// File: tb/tb_d_e_stage.sv
// Directed bench for d_e_stage: capture, extension, forwarding, load-use, hold/flush, bubble, async reset.
module tb_d_e_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        D_valid;
  logic [31:0] D_PC, D_rs_data, D_rt_data;
  logic [4:0]  D_rs_addr, D_rt_addr, D_rd_addr;
  logic [15:0] D_imm16;
  logic [2:0]  D_ALUcontrol;
  logic        D_ALUSrc, D_ExtOp, D_uses_rt, D_RegWrite, D_MemWrite, D_MemtoReg;
  logic        E_hold, E_flush;
  logic        M_RegWrite;
  logic [4:0]  M_rd_addr;
  logic [31:0] M_fwd_data;
  logic        W_RegWrite;
  logic [4:0]  W_rd_addr;
  logic [31:0] W_fwd_data;
  logic [2:0]  ALUcontrol;
  logic [31:0] Op1, Op2, E_wdata, E_PC;
  logic [4:0]  E_rd_addr;
  logic        E_RegWrite, E_MemWrite, E_MemtoReg, E_valid, stall_req;

  int checks = 0;
  int errors = 0;

  d_e_stage #(.WIDTH(32), .RADDR(5)) dut (
    .clk(clk), .rst_n(rst_n), .D_valid(D_valid), .D_PC(D_PC),
    .D_rs_data(D_rs_data), .D_rt_data(D_rt_data), .D_rs_addr(D_rs_addr),
    .D_rt_addr(D_rt_addr), .D_rd_addr(D_rd_addr), .D_imm16(D_imm16),
    .D_ALUcontrol(D_ALUcontrol), .D_ALUSrc(D_ALUSrc), .D_ExtOp(D_ExtOp),
    .D_uses_rt(D_uses_rt), .D_RegWrite(D_RegWrite), .D_MemWrite(D_MemWrite),
    .D_MemtoReg(D_MemtoReg), .E_hold(E_hold), .E_flush(E_flush),
    .M_RegWrite(M_RegWrite), .M_rd_addr(M_rd_addr), .M_fwd_data(M_fwd_data),
    .W_RegWrite(W_RegWrite), .W_rd_addr(W_rd_addr), .W_fwd_data(W_fwd_data),
    .ALUcontrol(ALUcontrol), .Op1(Op1), .Op2(Op2), .E_wdata(E_wdata),
    .E_rd_addr(E_rd_addr), .E_RegWrite(E_RegWrite), .E_MemWrite(E_MemWrite),
    .E_MemtoReg(E_MemtoReg), .E_PC(E_PC), .E_valid(E_valid), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_d();
    D_valid = 0; D_PC = 0; D_rs_data = 0; D_rt_data = 0;
    D_rs_addr = 0; D_rt_addr = 0; D_rd_addr = 0; D_imm16 = 0;
    D_ALUcontrol = 0; D_ALUSrc = 0; D_ExtOp = 0; D_uses_rt = 0;
    D_RegWrite = 0; D_MemWrite = 0; D_MemtoReg = 0;
  endtask

  initial begin
    rst_n = 0; clear_d();
    E_hold = 0; E_flush = 0;
    M_RegWrite = 0; M_rd_addr = 0; M_fwd_data = 0;
    W_RegWrite = 0; W_rd_addr = 0; W_fwd_data = 0;
    tick(); tick();
    check("rst_valid", {31'd0, E_valid}, 32'd0);
    check("rst_op1", Op1, 32'd0);
    check("rst_op2", Op2, 32'd0);
    check("rst_pc", E_PC, 32'd0);
    rst_n = 1;

    // Plain capture
    D_valid = 1; D_PC = 32'h100; D_rs_data = 32'hf0000000; D_rt_data = 32'hf0000002;
    D_rs_addr = 1; D_rt_addr = 2; D_rd_addr = 3; D_ALUcontrol = 3'b110; D_RegWrite = 1;
    tick();
    check("cap_op1", Op1, 32'hf0000000);
    check("cap_op2", Op2, 32'hf0000002);
    check("cap_aluctl", {29'd0, ALUcontrol}, 32'd6);
    check("cap_valid", {31'd0, E_valid}, 32'd1);
    check("cap_pc", E_PC, 32'h100);
    check("cap_rd", {27'd0, E_rd_addr}, 32'd3);
    check("cap_wdata", E_wdata, 32'hf0000002);
    check("cap_regwrite", {31'd0, E_RegWrite}, 32'd1);

    // Immediate extension
    D_imm16 = 16'h8001; D_ALUSrc = 1; D_ExtOp = 1;
    tick();
    check("imm_sext", Op2, 32'hffff8001);
    check("imm_wdata", E_wdata, 32'hf0000002);
    D_ExtOp = 0;
    tick();
    check("imm_zext", Op2, 32'h00008001);

    // Forwarding priority
    D_ALUSrc = 0; D_rs_addr = 5; D_rs_data = 32'h12345678; D_rt_addr = 6; D_rt_data = 32'h66;
    tick();
    check("fwd_none", Op1, 32'h12345678);
    M_RegWrite = 1; M_rd_addr = 5; M_fwd_data = 32'h0000aaaa;
    W_RegWrite = 1; W_rd_addr = 5; W_fwd_data = 32'h0000bbbb;
    #1;
    check("fwd_m_over_w", Op1, 32'h0000aaaa);
    check("fwd_rt_nomatch", E_wdata, 32'h66);
    M_RegWrite = 0;
    #1;
    check("fwd_w", Op1, 32'h0000bbbb);
    W_rd_addr = 6;
    #1;
    check("fwd_w_rt_wdata", E_wdata, 32'h0000bbbb);
    check("fwd_w_rt_op2", Op2, 32'h0000bbbb);
    check("fwd_w_rs_gone", Op1, 32'h12345678);
    D_rs_addr = 0; D_rs_data = 0;
    tick();
    M_RegWrite = 1; M_rd_addr = 0; W_rd_addr = 0;
    #1;
    check("fwd_r0", Op1, 32'd0);
    M_RegWrite = 0; W_RegWrite = 0;

    // Load-use
    clear_d();
    D_valid = 1; D_rd_addr = 8; D_MemtoReg = 1; D_RegWrite = 1;
    tick();
    D_rs_addr = 1; D_rt_addr = 8; D_uses_rt = 1;
    #1;
    check("lu_rt", {31'd0, stall_req}, 32'd1);
    D_uses_rt = 0;
    #1;
    check("lu_rt_unused", {31'd0, stall_req}, 32'd0);
    D_rs_addr = 8;
    #1;
    check("lu_rs", {31'd0, stall_req}, 32'd1);
    clear_d();
    D_valid = 1; D_rd_addr = 0; D_MemtoReg = 1; D_RegWrite = 1;
    tick();
    D_rs_addr = 0; D_rt_addr = 0; D_uses_rt = 1;
    #1;
    check("lu_rd0", {31'd0, stall_req}, 32'd0);

    // Hold beats flush, then flush alone
    clear_d();
    D_valid = 1; D_PC = 32'h200; D_rd_addr = 9; D_RegWrite = 1; D_MemWrite = 1;
    tick();
    D_PC = 32'h300; D_rd_addr = 10; D_MemWrite = 0;
    E_hold = 1; E_flush = 1;
    tick();
    check("hold_pc", E_PC, 32'h200);
    check("hold_valid", {31'd0, E_valid}, 32'd1);
    check("hold_memwrite", {31'd0, E_MemWrite}, 32'd1);
    check("hold_rd", {27'd0, E_rd_addr}, 32'd9);
    E_hold = 0;
    tick();
    check("flush_valid", {31'd0, E_valid}, 32'd0);
    check("flush_regwrite", {31'd0, E_RegWrite}, 32'd0);
    check("flush_memwrite", {31'd0, E_MemWrite}, 32'd0);
    check("flush_pc", E_PC, 32'd0);
    E_flush = 0;

    // D_valid=0 captures a bubble
    D_valid = 0; D_PC = 32'h400; D_RegWrite = 1;
    tick();
    check("bubble_valid", {31'd0, E_valid}, 32'd0);
    check("bubble_pc", E_PC, 32'd0);
    check("bubble_regwrite", {31'd0, E_RegWrite}, 32'd0);

    // Asynchronous reset mid-cycle
    clear_d();
    D_valid = 1; D_PC = 32'h500; D_rs_data = 32'hdead0001; D_rs_addr = 4;
    D_rt_data = 32'hbeef0002; D_rt_addr = 7; D_rd_addr = 4; D_ALUcontrol = 3'b010; D_RegWrite = 1;
    tick();
    check("pre_rst_op1", Op1, 32'hdead0001);
    #2;
    rst_n = 0;
    #1;
    check("arst_op1", Op1, 32'd0);
    check("arst_op2", Op2, 32'd0);
    check("arst_aluctl", {29'd0, ALUcontrol}, 32'd0);
    check("arst_valid", {31'd0, E_valid}, 32'd0);
    check("arst_pc", E_PC, 32'd0);
    check("arst_rd", {27'd0, E_rd_addr}, 32'd0);
    check("arst_regwrite", {31'd0, E_RegWrite}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
